// File: rtl/seq_pattern_capture.sv
// rtl/seq_pattern_capture.sv - programmable serial pattern detector with word capture and saturating match counter
module seq_pattern_capture #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 DATA_W  = 16,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic              d_in,
    input  logic [DATA_W-1:0] bit_in,
    input  logic              clear_cnt,
    output logic              pat_hit,
    output logic [DATA_W-1:0] bit_out,
    output logic              out_valid,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat
);

    localparam int                FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HUNT = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    // Only the PAT_LEN-1 previous bits need storing; the newest bit is d_in itself.
    logic [PAT_LEN-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   bit_out_q, bit_out_d;
    logic                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic                cnt_sat_q, cnt_sat_d;
    logic [PAT_LEN-1:0]  window;
    logic                match;

    assign pat_hit   = (state_q == HIT);
    assign bit_out   = bit_out_q;
    assign out_valid = out_valid_q;
    assign match_cnt = match_cnt_q;
    assign cnt_sat   = cnt_sat_q;

    // History shift, fill tracking and match detection; non-overlap mode flushes on a match.
    always_comb begin
        window = {hist_q, d_in};
        match  = d_valid && (fill_q == FILL_MAX) && (window == PATTERN);
        hist_d = hist_q;
        fill_d = fill_q;
        if (match && (OVERLAP == 0)) begin
            hist_d = '0;
            fill_d = '0;
        end else if (d_valid) begin
            hist_d = window[PAT_LEN-2:0];
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Next-state decode; a match always lands in HIT regardless of the state it arrives from.
    always_comb begin
        state_d = FILL;
        case (state_q)
            FILL, HUNT: begin
                if (match) begin
                    state_d = HIT;
                end else if (fill_d == FILL_MAX) begin
                    state_d = HUNT;
                end else begin
                    state_d = FILL;
                end
            end
            HIT: begin
                if (OVERLAP != 0) begin
                    state_d = match ? HIT : HUNT;
                end else begin
                    state_d = (fill_d == FILL_MAX) ? HUNT : FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Capture and counting happen on the edge that leaves HIT; clear_cnt beats a coincident increment.
    always_comb begin
        bit_out_d   = bit_out_q;
        out_valid_d = 1'b0;
        match_cnt_d = match_cnt_q;
        if (pat_hit) begin
            bit_out_d   = bit_in;
            out_valid_d = 1'b1;
        end
        if (clear_cnt) begin
            match_cnt_d = '0;
        end else if (pat_hit && (match_cnt_q != CNT_MAX)) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
        end
        cnt_sat_d = clear_cnt ? 1'b0 : (cnt_sat_q | (match_cnt_d == CNT_MAX));
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            hist_q      <= '0;
            fill_q      <= '0;
            bit_out_q   <= '0;
            out_valid_q <= 1'b0;
            match_cnt_q <= '0;
            cnt_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            bit_out_q   <= bit_out_d;
            out_valid_q <= out_valid_d;
            match_cnt_q <= match_cnt_d;
            cnt_sat_q   <= cnt_sat_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_capture.sv
// tb/tb_seq_pattern_capture.sv - randomized and directed bench for seq_pattern_capture against a bit-list model
module tb_seq_pattern_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        d_valid = 1'b0;
    logic        d_in = 1'b0;
    logic [15:0] bit_in = '0;
    logic        clear_cnt = 1'b0;

    logic [3:0]  hit_w;
    logic [3:0]  ov_w;
    logic [3:0]  sat_w;
    logic [15:0] bout0, bout1, bout2, bout3;
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;
    logic [7:0]  cnt2;
    logic [3:0]  cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    int          p_len  [4] = '{4, 4, 4, 8};
    logic [31:0] p_pat  [4] = '{32'hB, 32'hB, 32'h1, 32'hFF};
    int          p_ovl  [4] = '{1, 0, 1, 1};
    int          p_cntw [4] = '{8, 2, 8, 4};

    bit          seen [4][0:4095];
    int          nbits [4];
    logic        exp_hit [4];
    logic        exp_ov [4];
    logic        exp_sat [4];
    logic [15:0] exp_bout [4];
    int          exp_cnt [4];

    always #5 clk = ~clk;

    seq_pattern_capture u0 (
        .clk(clk), .rst(rst_n), .d_valid(d_valid), .d_in(d_in), .bit_in(bit_in),
        .clear_cnt(clear_cnt), .pat_hit(hit_w[0]), .bit_out(bout0), .out_valid(ov_w[0]),
        .match_cnt(cnt0), .cnt_sat(sat_w[0])
    );

    seq_pattern_capture #(.OVERLAP(0), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst_n), .d_valid(d_valid), .d_in(d_in), .bit_in(bit_in),
        .clear_cnt(clear_cnt), .pat_hit(hit_w[1]), .bit_out(bout1), .out_valid(ov_w[1]),
        .match_cnt(cnt1), .cnt_sat(sat_w[1])
    );

    seq_pattern_capture #(.PATTERN(4'b0001)) u2 (
        .clk(clk), .rst(rst_n), .d_valid(d_valid), .d_in(d_in), .bit_in(bit_in),
        .clear_cnt(clear_cnt), .pat_hit(hit_w[2]), .bit_out(bout2), .out_valid(ov_w[2]),
        .match_cnt(cnt2), .cnt_sat(sat_w[2])
    );

    seq_pattern_capture #(.PAT_LEN(8), .PATTERN(8'hFF), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst_n), .d_valid(d_valid), .d_in(d_in), .bit_in(bit_in),
        .clear_cnt(clear_cnt), .pat_hit(hit_w[3]), .bit_out(bout3), .out_valid(ov_w[3]),
        .match_cnt(cnt3), .cnt_sat(sat_w[3])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_cnt(input int i);
        case (i)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            2:       return 32'(cnt2);
            default: return 32'(cnt3);
        endcase
    endfunction

    function automatic logic [31:0] obs_bout(input int i);
        case (i)
            0:       return 32'(bout0);
            1:       return 32'(bout1);
            2:       return 32'(bout2);
            default: return 32'(bout3);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            nbits[i]    = 0;
            exp_hit[i]  = 1'b0;
            exp_ov[i]   = 1'b0;
            exp_sat[i]  = 1'b0;
            exp_bout[i] = '0;
            exp_cnt[i]  = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            logic hp;
            logic m;
            int   maxc;
            hp   = exp_hit[i];
            maxc = (1 << p_cntw[i]) - 1;
            if (clear_cnt) begin
                exp_cnt[i] = 0;
                exp_sat[i] = 1'b0;
            end else if (hp) begin
                if (exp_cnt[i] < maxc) exp_cnt[i]++;
                if (exp_cnt[i] == maxc) exp_sat[i] = 1'b1;
            end
            exp_ov[i] = hp;
            if (hp) exp_bout[i] = bit_in;
            m = 1'b0;
            if (d_valid) begin
                seen[i][nbits[i]] = d_in;
                nbits[i]++;
                if (nbits[i] >= p_len[i]) begin
                    m = 1'b1;
                    for (int j = 0; j < p_len[i]; j++) begin
                        if (seen[i][nbits[i]-1-j] != p_pat[i][j]) m = 1'b0;
                    end
                end
                if (m && (p_ovl[i] == 0)) nbits[i] = 0;
            end
            exp_hit[i] = m;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("pat_hit%0d", i),   32'(hit_w[i]), 32'(exp_hit[i]));
            check_eq($sformatf("out_valid%0d", i), 32'(ov_w[i]),  32'(exp_ov[i]));
            check_eq($sformatf("bit_out%0d", i),   obs_bout(i),   32'(exp_bout[i]));
            check_eq($sformatf("match_cnt%0d", i), obs_cnt(i),    32'(exp_cnt[i]));
            check_eq($sformatf("cnt_sat%0d", i),   32'(sat_w[i]), 32'(exp_sat[i]));
        end
    endtask

    task automatic do_reset();
        d_valid   = 1'b0;
        clear_cnt = 1'b0;
        rst_n     = 1'b0;
        #2;
        model_reset();
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic step(input logic dv, input logic di, input logic clr);
        d_valid   = dv;
        d_in      = di;
        clear_cnt = clr;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_1011();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [6:0] s2;
        #1;
        do_reset();

        // First detection, capture and count
        bit_in = 16'hA5A5;
        send_1011();
        check_eq("t1_hit", 32'(hit_w[0]), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("t1_bout", 32'(bout0), 32'hA5A5);
        check_eq("t1_valid", 32'(ov_w[0]), 32'd1);
        check_eq("t1_cnt", 32'(cnt0), 32'd1);

        // Overlapping versus flushing on 1011011
        do_reset();
        s2 = 7'b1011011;
        for (int k = 6; k >= 0; k--) step(1'b1, s2[k], 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("t2_cnt_ovl", 32'(cnt0), 32'd2);
        check_eq("t2_cnt_novl", 32'(cnt1), 32'd1);

        // Gaps in d_valid between pattern bits
        do_reset();
        bit_in = 16'h1234;
        s2 = 7'b0001011;
        for (int k = 3; k >= 0; k--) begin
            step(1'b1, s2[k], 1'b0);
            repeat (3) step(1'b0, 1'b0, 1'b0);
        end
        check_eq("t3_cnt", 32'(cnt0), 32'd1);
        check_eq("t3_bout", 32'(bout0), 32'h1234);

        // Saturation of a 2-bit counter, then clear on a counting edge
        do_reset();
        repeat (5) send_1011();
        step(1'b0, 1'b0, 1'b0);
        check_eq("t4_cnt_sat_val", 32'(cnt1), 32'd3);
        check_eq("t4_sat", 32'(sat_w[1]), 32'd1);
        send_1011();
        step(1'b0, 1'b0, 1'b1);
        check_eq("t4_clr_cnt", 32'(cnt1), 32'd0);
        check_eq("t4_clr_sat", 32'(sat_w[1]), 32'd0);

        // Reset zeros must not complete 0001
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("t5_nohit", 32'(hit_w[2]), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("t5_hit", 32'(hit_w[2]), 32'd1);

        // A pattern in progress does not survive reset
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        check_eq("t5_rst_nohit", 32'(hit_w[0]), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("t5_rst_bout", 32'(bout0), 32'd0);

        // All-ones stream against an 8-bit all-ones pattern
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b1, 1'b0);
            check_eq($sformatf("t6_hit_bit%0d", k), 32'(hit_w[3]), (k >= 8) ? 32'd1 : 32'd0);
        end

        // Randomized traffic with occasional clears and resets
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            logic dv;
            logic di;
            logic clr;
            bit_in = 16'($urandom);
            dv  = ($urandom_range(0, 3) != 0);
            di  = (n < 1000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            step(dv, di, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
